// File: rtl/dcache_arbiter_if.sv
// Requester/cache bundle for dcache_arbiter; arbiter takes the slave modport,
// the requester/cache side (or a bench) takes the master modport.
interface dcache_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ-1:0]           i_req_write;
  logic [NUM_REQ*ADDR_SIZE-1:0] i_addr;
  logic [NUM_REQ*DATA_SIZE-1:0] i_wdata;
  logic [NUM_REQ*2-1:0]         i_sop;
  logic [NUM_REQ*3-1:0]         i_ldop;
  logic [NUM_REQ-1:0]           o_gnt;
  logic [NUM_REQ-1:0]           o_done;
  logic [DATA_SIZE-1:0]         o_rdata;
  logic                         o_c_req;
  logic                         o_c_req_write;
  logic [ADDR_SIZE-1:0]         o_c_addr;
  logic [DATA_SIZE-1:0]         o_c_store_data;
  logic [1:0]                   o_c_sop;
  logic [2:0]                   o_c_ldop;
  logic                         i_c_ready;
  logic                         i_c_data_valid;
  logic [DATA_SIZE-1:0]         i_c_data;

  modport slave (
    input  i_req, i_req_write, i_addr, i_wdata, i_sop, i_ldop,
    input  i_c_ready, i_c_data_valid, i_c_data,
    output o_gnt, o_done, o_rdata,
    output o_c_req, o_c_req_write, o_c_addr, o_c_store_data, o_c_sop, o_c_ldop
  );

  modport master (
    output i_req, i_req_write, i_addr, i_wdata, i_sop, i_ldop,
    output i_c_ready, i_c_data_valid, i_c_data,
    input  o_gnt, o_done, o_rdata,
    input  o_c_req, o_c_req_write, o_c_addr, o_c_store_data, o_c_sop, o_c_ldop
  );
endinterface

// File: rtl/dcache_arbiter.sv
// Shares one data_cache request port among NUM_REQ requesters, one transaction at a time.
// Round-robin by default; define DCARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module dcache_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input logic              i_aclk,
  input logic              i_areset,
  dcache_arbiter_if.slave  bus
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                 state_q, state_d;
  logic                   take, finish;
  logic [IDXW-1:0]        rr_ptr_q, win_q, win_sel;
  logic                   found;
  logic                   sel_write;
  logic [ADDR_SIZE-1:0]   sel_addr;
  logic [DATA_SIZE-1:0]   sel_wdata;
  logic [1:0]             sel_sop;
  logic [2:0]             sel_ldop;
  logic                   wr_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [DATA_SIZE-1:0]   wdata_q;
  logic [1:0]             sop_q;
  logic [2:0]             ldop_q;
  logic [DATA_SIZE-1:0]   rdata_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [NUM_REQ-1:0]     win_onehot;
  logic [NUM_REQ-1:0]     gnt;

  // Scan requesters starting at rr_ptr_q and wrapping; the first hit wins.
  always_comb begin
    int unsigned k;
    k         = 0;
    found     = 1'b0;
    win_sel   = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_sop   = '0;
    sel_ldop  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = 32'(rr_ptr_q) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && bus.i_req[k]) begin
        found     = 1'b1;
        win_sel   = IDXW'(k);
        sel_write = bus.i_req_write[k];
        sel_addr  = bus.i_addr[k*ADDR_SIZE +: ADDR_SIZE];
        sel_wdata = bus.i_wdata[k*DATA_SIZE +: DATA_SIZE];
        sel_sop   = bus.i_sop[k*2 +: 2];
        sel_ldop  = bus.i_ldop[k*3 +: 3];
      end
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && bus.i_c_ready) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Stores finish on cache ready, loads on returned data.
        if (wr_q ? bus.i_c_ready : bus.i_c_data_valid) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = (32'(win_q) == i);
    end
    gnt = (state_q != IDLE) ? win_onehot : '0;
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      rr_ptr_q <= '0;
      win_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sop_q    <= '0;
      ldop_q   <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
    end else begin
      done_q <= '0;
      if (take) begin
        win_q   <= win_sel;
        wr_q    <= sel_write;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        sop_q   <= sel_sop;
        ldop_q  <= sel_ldop;
      end
      if (finish) begin
        done_q <= win_onehot;
        if (!wr_q) rdata_q <= bus.i_c_data;
`ifdef DCARB_FIXED_PRIO_EN
        rr_ptr_q <= '0;
`else
        rr_ptr_q <= (win_q == IDXW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
      end
    end
  end

  assign bus.o_gnt          = gnt;
  assign bus.o_done         = done_q;
  assign bus.o_rdata        = rdata_q;
  assign bus.o_c_req        = (state_q == ISSUE);
  assign bus.o_c_req_write  = wr_q;
  assign bus.o_c_addr       = addr_q;
  assign bus.o_c_store_data = wdata_q;
  assign bus.o_c_sop        = sop_q;
  assign bus.o_c_ldop       = ldop_q;

endmodule
